aether_mem_sequencer: RTL and testbench

AETHER_MEM_SEQUENCER -- requirements
Module: aether_mem_sequencer

---
 rtl/aether_pkg.sv | 7 +
 rtl/aether_mem_sequencer.sv | 124 ++++++++++++
 tb/tb_aether_mem_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/aether_pkg.sv
// aether_pkg: shared Aether types and default stats-upper codes.
package aether_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} seq_state_e;
    localparam logic [7:0] STAT_DONE  = 8'h01;
    localparam logic [7:0] STAT_ERR   = 8'h02;
    localparam logic [7:0] STAT_ABORT = 8'h04;
endpackage

// File: rtl/aether_mem_sequencer.sv
// aether_mem_sequencer: sweeps {memup, low} from mstrt to mendd over a valid/ready beat port.
module aether_mem_sequencer
    import aether_pkg::*;
#(
    parameter logic [7:0] StatDone  = STAT_DONE,
    parameter logic [7:0] StatErr   = STAT_ERR,
    parameter logic [7:0] StatAbort = STAT_ABORT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [15:0] reg_memup_i,
    input  logic [15:0] reg_mstrt_i,
    input  logic [15:0] reg_mendd_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic        mem_last_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [16:0] beat_cnt_o,
    output logic [7:0]  stats_upper_o,
    output logic        we_stats_upper_o
);
    seq_state_e  state_q, state_d;
    logic [15:0] mendd_q, mendd_d, low_nxt;
    logic [31:0] addr_d;
    logic [16:0] cnt_d;
    logic [7:0]  stats_d;
    logic        valid_d, last_d, busy_d, done_d, err_d, we_d, fire;

    assign low_nxt = mem_addr_o[15:0] + 16'd1;
    assign fire    = mem_valid_o & mem_ready_i;

    // Every output is computed one cycle ahead and registered, so none depends combinationally on inputs.
    always_comb begin
        state_d = state_q;
        mendd_d = mendd_q;
        addr_d  = mem_addr_o;
        cnt_d   = beat_cnt_o;
        stats_d = stats_upper_o;
        err_d   = err_o;
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        we_d    = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                mendd_d = reg_mendd_i;
                cnt_d   = '0;
                busy_d  = 1'b1;
                if (reg_mendd_i < reg_mstrt_i) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    we_d    = 1'b1;
                    stats_d = StatErr;
                end else begin
                    state_d = RUN;
                    err_d   = 1'b0;
                    addr_d  = {reg_memup_i, reg_mstrt_i};
                    valid_d = 1'b1;
                    last_d  = reg_mstrt_i == reg_mendd_i;
                end
            end
            RUN: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
                last_d  = mem_last_o;
                if (fire) cnt_d = beat_cnt_o + 17'd1;
                // Stop on the last beat instead of incrementing, so an end of FFFF never wraps.
                if (fire && mem_last_o) begin
                    state_d = DONE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    we_d    = 1'b1;
                    stats_d = StatDone;
                end else if (abort_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    we_d    = 1'b1;
                    stats_d = StatAbort;
                end else if (fire) begin
                    addr_d = {mem_addr_o[31:16], low_nxt};
                    last_d = low_nxt == mendd_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            mendd_q          <= '0;
            mem_addr_o       <= '0;
            mem_valid_o      <= 1'b0;
            mem_last_o       <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
            err_o            <= 1'b0;
            beat_cnt_o       <= '0;
            stats_upper_o    <= '0;
            we_stats_upper_o <= 1'b0;
        end else begin
            state_q          <= state_d;
            mendd_q          <= mendd_d;
            mem_addr_o       <= addr_d;
            mem_valid_o      <= valid_d;
            mem_last_o       <= last_d;
            busy_o           <= busy_d;
            done_o           <= done_d;
            err_o            <= err_d;
            beat_cnt_o       <= cnt_d;
            stats_upper_o    <= stats_d;
            we_stats_upper_o <= we_d;
        end
    end
endmodule

// File: tb/tb_aether_mem_sequencer.sv
// tb_aether_mem_sequencer: table-driven vectors plus directed multi-cycle sequences.
module tb_aether_mem_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, start, abort, ready;
    logic [15:0] memup, mstrt, mendd;
    logic [31:0] addr;
    logic        valid, last, busy, done, err, we;
    logic [16:0] cnt;
    logic [7:0]  stats;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    aether_mem_sequencer dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
        .reg_memup_i(memup), .reg_mstrt_i(mstrt), .reg_mendd_i(mendd),
        .mem_addr_o(addr), .mem_valid_o(valid), .mem_ready_i(ready), .mem_last_o(last),
        .busy_o(busy), .done_o(done), .err_o(err), .beat_cnt_o(cnt),
        .stats_upper_o(stats), .we_stats_upper_o(we)
    );

    typedef struct {
        logic        rst_n, start, abort, ready;
        logic [15:0] up, st, en;
        logic        v, l, b, d, e, w;
        logic [7:0]  stats;
        logic [16:0] cnt;
        logic [31:0] addr;
    } vec_t;

    vec_t tbl [20];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic v, l, b, d, e, w,
                              input logic [7:0] s, input logic [16:0] c, input logic [31:0] a);
        logic [62:0] got, req;
        got = {valid, last, busy, done, err, we, stats, cnt, addr};
        req = {v, l, b, d, e, w, s, c, a};
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got v%b l%b b%b d%b e%b we%b st=%h cnt=%0d addr=%h, want v%b l%b b%b d%b e%b we%b st=%h cnt=%0d addr=%h",
                     name, valid, last, busy, done, err, we, stats, cnt, addr, v, l, b, d, e, w, s, c, a);
        end
    endtask

    task automatic drive(input logic r, s, ab, rd, input logic [15:0] u, st, en);
        rst_n = r; start = s; abort = ab; ready = rd; memup = u; mstrt = st; mendd = en;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        //            rst st  ab  rdy  up       st       en        v  l  b  d  e  w  stats  cnt    addr
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,16'h0000,16'h0000,16'h0000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00,17'd0,32'h00000000};
        tbl[1]  = '{1'b1,1'b1,1'b0,1'b1,16'h0001,16'h0010,16'h0013,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'h00,17'd0,32'h00010010};
        tbl[2]  = '{1'b1,1'b0,1'b0,1'b1,16'hAAAA,16'hAAAA,16'hAAAA,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'h00,17'd1,32'h00010011};
        tbl[3]  = '{1'b1,1'b0,1'b0,1'b1,16'hAAAA,16'hAAAA,16'hAAAA,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'h00,17'd2,32'h00010012};
        tbl[4]  = '{1'b1,1'b0,1'b0,1'b1,16'hAAAA,16'hAAAA,16'hAAAA,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,8'h00,17'd3,32'h00010013};
        tbl[5]  = '{1'b1,1'b0,1'b0,1'b1,16'hAAAA,16'hAAAA,16'hAAAA,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,8'h01,17'd4,32'h00010013};
        tbl[6]  = '{1'b1,1'b0,1'b0,1'b1,16'hAAAA,16'hAAAA,16'hAAAA,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h01,17'd4,32'h00010013};
        tbl[7]  = '{1'b1,1'b1,1'b0,1'b0,16'h0002,16'h0100,16'h0102,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'h01,17'd0,32'h00020100};
        tbl[8]  = '{1'b1,1'b0,1'b0,1'b1,16'h0002,16'h0100,16'h0102,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'h01,17'd1,32'h00020101};
        tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,16'h0002,16'h0100,16'h0102,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'h01,17'd1,32'h00020101};
        tbl[10] = '{1'b1,1'b0,1'b0,1'b0,16'h0002,16'h0100,16'h0102,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,8'h01,17'd1,32'h00020101};
        tbl[11] = '{1'b1,1'b0,1'b0,1'b1,16'h0002,16'h0100,16'h0102,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,8'h01,17'd2,32'h00020102};
        tbl[12] = '{1'b1,1'b0,1'b0,1'b1,16'h0002,16'h0100,16'h0102,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,8'h01,17'd3,32'h00020102};
        tbl[13] = '{1'b1,1'b0,1'b0,1'b0,16'h0002,16'h0100,16'h0102,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h01,17'd3,32'h00020102};
        tbl[14] = '{1'b1,1'b1,1'b0,1'b1,16'h0003,16'h0020,16'h001F,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,8'h02,17'd0,32'h00020102};
        tbl[15] = '{1'b1,1'b0,1'b0,1'b1,16'h0003,16'h0020,16'h001F,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'h02,17'd0,32'h00020102};
        tbl[16] = '{1'b1,1'b0,1'b1,1'b1,16'h0003,16'h0020,16'h001F,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'h02,17'd0,32'h00020102};
        tbl[17] = '{1'b1,1'b1,1'b0,1'b0,16'h0001,16'h0005,16'h0005,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,8'h02,17'd0,32'h00010005};
        tbl[18] = '{1'b1,1'b0,1'b0,1'b1,16'h0001,16'h0005,16'h0005,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,8'h01,17'd1,32'h00010005};
        tbl[19] = '{1'b1,1'b0,1'b0,1'b0,16'h0001,16'h0005,16'h0005,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,8'h01,17'd1,32'h00010005};

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst_n, tbl[i].start, tbl[i].abort, tbl[i].ready, tbl[i].up, tbl[i].st, tbl[i].en);
            step();
            expect_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].l, tbl[i].b, tbl[i].d, tbl[i].e,
                       tbl[i].w, tbl[i].stats, tbl[i].cnt, tbl[i].addr);
        end

        // Wrap boundary: end at FFFF must stop after two beats.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h00AB, 16'hFFFE, 16'hFFFF);
        step(); expect_out("wrap_b1", 1, 0, 1, 0, 0, 0, 8'h01, 17'd0, 32'h00ABFFFE);
        start = 1'b0;
        step(); expect_out("wrap_b2", 1, 1, 1, 0, 0, 0, 8'h01, 17'd1, 32'h00ABFFFF);
        step(); expect_out("wrap_done", 0, 0, 1, 1, 0, 1, 8'h01, 17'd2, 32'h00ABFFFF);
        step(); expect_out("wrap_idle", 0, 0, 0, 0, 0, 0, 8'h01, 17'd2, 32'h00ABFFFF);

        // Abort after two of eight beats, with the third beat left unaccepted.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0007, 16'h0000, 16'h0007);
        step(); expect_out("ab_start", 1, 0, 1, 0, 0, 0, 8'h01, 17'd0, 32'h00070000);
        start = 1'b0;
        step(); expect_out("ab_b1", 1, 0, 1, 0, 0, 0, 8'h01, 17'd1, 32'h00070001);
        step(); expect_out("ab_b2", 1, 0, 1, 0, 0, 0, 8'h01, 17'd2, 32'h00070002);
        ready = 1'b0; abort = 1'b1;
        step(); expect_out("ab_drop", 0, 0, 0, 0, 0, 1, 8'h04, 17'd2, 32'h00070002);
        abort = 1'b0;
        step(); expect_out("ab_idle", 0, 0, 0, 0, 0, 0, 8'h04, 17'd2, 32'h00070002);

        // Abort coinciding with the last beat: completion wins.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0008, 16'h0000, 16'h0001);
        step(); expect_out("co_start", 1, 0, 1, 0, 0, 0, 8'h04, 17'd0, 32'h00080000);
        start = 1'b0;
        step(); expect_out("co_last", 1, 1, 1, 0, 0, 0, 8'h04, 17'd1, 32'h00080001);
        abort = 1'b1;
        step(); expect_out("co_done", 0, 0, 1, 1, 0, 1, 8'h01, 17'd2, 32'h00080001);
        abort = 1'b0;
        step(); expect_out("co_idle", 0, 0, 0, 0, 0, 0, 8'h01, 17'd2, 32'h00080001);

        // Reset mid-sweep, then a start during busy must be ignored.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0009, 16'h0000, 16'h0007);
        step(); step();
        expect_out("rs_run", 1, 0, 1, 0, 0, 0, 8'h01, 17'd1, 32'h00090001);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0009, 16'h0000, 16'h0007);
        step(); expect_out("rs_zero", 0, 0, 0, 0, 0, 0, 8'h00, 17'd0, 32'h00000000);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0009, 16'h0000, 16'h0003);
        step(); expect_out("rs_restart", 1, 0, 1, 0, 0, 0, 8'h00, 17'd0, 32'h00090000);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0005, 16'h0050, 16'h0060);
        step(); expect_out("rs_ign_start", 1, 0, 1, 0, 0, 0, 8'h00, 17'd1, 32'h00090001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
